multicycle_ctrl: RTL and testbench

//  Multicycle control unit sitting directly upstream of the RISC-V datapath.

---
 rtl/riscv_ctrl_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_if.sv | 30 +++
 rtl/alu_ctrl_decode.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 141 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the multicycle RISC-V control unit:
// opcodes, ALU operation codes, FSM state encoding and the control bundle.
package riscv_ctrl_pkg;

  // Supported major opcodes (IR[6:0])
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU operation codes understood by the datapath
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  typedef enum logic [2:0] {
    ST_IF,
    ST_ID,
    ST_EX,
    ST_MEM,
    ST_WB,
    ST_ERR
  } state_t;

  // Registered Moore outputs of the controller (PCSrc is handled separately)
  typedef struct packed {
    logic       imem_read;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       load_pc;
    logic       mem_read;
    logic       mem_write;
    logic       illegal;
    logic [3:0] alu_ctrl;
  } ctrl_out_t;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/instruction-memory signal bundle.
// master = control unit side, slave = datapath side.
interface multicycle_ctrl_if;
  logic [31:0] iMemReadData;
  logic        Zero;
  logic [31:0] instruction;
  logic        iMemRead;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemtoReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic        illegal;
  logic [31:0] retired;

  modport master (
    input  iMemReadData, Zero,
    output instruction, iMemRead, PCSrc, ALUSrc, RegWrite, MemtoReg,
           ALUCtrl, loadPC, MemRead, MemWrite, illegal, retired
  );

  modport slave (
    output iMemReadData, Zero,
    input  instruction, iMemRead, PCSrc, ALUSrc, RegWrite, MemtoReg,
           ALUCtrl, loadPC, MemRead, MemWrite, illegal, retired
  );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU operation decode from {opcode, funct3, funct7[5]}.
// Anything not explicitly recognised falls back to ADD.
module alu_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctrl
);

  // Decode the ALU operation for the instruction class
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_R: begin
        case ({funct7_5, funct3})
          4'b0000: alu_ctrl = ALU_ADD;
          4'b1000: alu_ctrl = ALU_SUB;
          4'b0111: alu_ctrl = ALU_AND;
          4'b0110: alu_ctrl = ALU_OR;
          4'b0100: alu_ctrl = ALU_XOR;
          4'b0010: alu_ctrl = ALU_SLT;
          4'b0001: alu_ctrl = ALU_SLL;
          4'b0101: alu_ctrl = ALU_SRL;
          4'b1101: alu_ctrl = ALU_SRA;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      OP_I: begin
        // funct7[5] only distinguishes SRAI from SRLI; it is an immediate bit otherwise
        case (funct3)
          3'b000:  alu_ctrl = ALU_ADD;
          3'b111:  alu_ctrl = ALU_AND;
          3'b110:  alu_ctrl = ALU_OR;
          3'b100:  alu_ctrl = ALU_XOR;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b001:  alu_ctrl = ALU_SLL;
          3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      OP_BEQ:  alu_ctrl = ALU_SUB;
      default: alu_ctrl = ALU_ADD;  // LW/SW address add, illegal opcodes
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: instruction register, IF/ID/EX/MEM/WB sequencer,
// retired-instruction counter and datapath control generation.
// Controls are registered and computed from the next state/IR so that they
// line up with the state they belong to; PCSrc follows Zero combinationally
// during BEQ EX.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR        = 32'h0000_0013,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input logic               clk,
  input logic               rst,
  multicycle_ctrl_if.master bus
);

  // Only the fetch strobe is active while held in reset (state IF)
  localparam ctrl_out_t RESET_OUT = '{
    imem_read:  1'b1,
    alu_src:    1'b0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    load_pc:    1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    illegal:    1'b0,
    alu_ctrl:   ALU_ADD
  };

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  ctrl_out_t   out_q, out_d;
  logic [3:0]  alu_ctrl_dec;
  logic [6:0]  op_q, op_d;

  assign op_q = ir_q[6:0];
  assign op_d = ir_d[6:0];

  alu_ctrl_decode u_alu_ctrl_decode (
    .opcode   (ir_d[6:0]),
    .funct3   (ir_d[14:12]),
    .funct7_5 (ir_d[30]),
    .alu_ctrl (alu_ctrl_dec)
  );

  // Next state, IR capture and retired counter
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q + {31'd0, out_q.load_pc};
    case (state_q)
      ST_IF: begin
        ir_d    = bus.iMemReadData;
        state_d = ST_ID;
      end
      ST_ID: begin
        if (is_legal(op_q)) begin
          state_d = ST_EX;
        end else if (HALT_ON_ILLEGAL) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_IF;
        end
      end
      ST_EX: begin
        case (op_q)
          OP_R, OP_I:   state_d = ST_WB;
          OP_LW, OP_SW: state_d = ST_MEM;
          default:      state_d = ST_IF;  // BEQ completes here
        endcase
      end
      ST_MEM:  state_d = (op_q == OP_LW) ? ST_WB : ST_IF;
      ST_WB:   state_d = ST_IF;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IF;
    endcase
  end

  // Control decode for the state being entered, from the IR it will hold
  always_comb begin
    out_d          = '0;
    out_d.alu_ctrl = ALU_ADD;
    case (state_d)
      ST_IF: out_d.imem_read = 1'b1;
      ST_ID: out_d.load_pc   = !is_legal(op_d) && !HALT_ON_ILLEGAL;
      ST_EX: begin
        out_d.alu_src  = (op_d == OP_I) || (op_d == OP_LW) || (op_d == OP_SW);
        out_d.alu_ctrl = alu_ctrl_dec;
        out_d.load_pc  = (op_d == OP_BEQ);
      end
      ST_MEM: begin
        // Operand selection held from EX so the data address stays valid
        out_d.alu_src   = 1'b1;
        out_d.alu_ctrl  = alu_ctrl_dec;
        out_d.mem_read  = (op_d == OP_LW);
        out_d.mem_write = (op_d == OP_SW);
        out_d.load_pc   = (op_d == OP_SW);
      end
      ST_WB: begin
        out_d.alu_src    = (op_d != OP_R);
        out_d.alu_ctrl   = alu_ctrl_dec;
        out_d.reg_write  = 1'b1;
        out_d.mem_to_reg = (op_d == OP_LW);
        out_d.load_pc    = 1'b1;
      end
      ST_ERR:  out_d.illegal = 1'b1;
      default: out_d = RESET_OUT;
    endcase
  end

  // State, IR, counter and registered controls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IF;
      ir_q      <= RESET_IR;
      retired_q <= '0;
      out_q     <= RESET_OUT;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      out_q     <= out_d;
    end
  end

  assign bus.instruction = ir_q;
  assign bus.iMemRead    = out_q.imem_read;
  assign bus.ALUSrc      = out_q.alu_src;
  assign bus.RegWrite    = out_q.reg_write;
  assign bus.MemtoReg    = out_q.mem_to_reg;
  assign bus.ALUCtrl     = out_q.alu_ctrl;
  assign bus.loadPC      = out_q.load_pc;
  assign bus.MemRead     = out_q.mem_read;
  assign bus.MemWrite    = out_q.mem_write;
  assign bus.illegal     = out_q.illegal;
  assign bus.retired     = retired_q;
  // Branch decision is taken from the live Zero flag in BEQ EX only
  assign bus.PCSrc       = (state_q == ST_EX) && (op_q == OP_BEQ) && bus.Zero;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table for legal
// instructions plus hand-written illegal-opcode and mid-instruction reset sequences.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if ifc ();
  multicycle_ctrl_if ifs ();

  multicycle_ctrl #(.RESET_IR(32'h0000_0013), .HALT_ON_ILLEGAL(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  multicycle_ctrl #(.RESET_IR(32'h0000_0013), .HALT_ON_ILLEGAL(1'b0)) u_dut_skip (
    .clk (clk),
    .rst (rst),
    .bus (ifs)
  );

  // {iMemRead, ALUSrc, RegWrite, MemtoReg, loadPC, MemRead, MemWrite, PCSrc}
  logic [7:0] ctrl_act;
  assign ctrl_act = {ifc.iMemRead, ifc.ALUSrc, ifc.RegWrite, ifc.MemtoReg,
                     ifc.loadPC, ifc.MemRead, ifc.MemWrite, ifc.PCSrc};

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic [7:0]  ctrl;
    logic [7:0]  mask;
    logic        alu_chk;
    logic [3:0]  alu;
    logic        ir_chk;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [31:0] W_ADD  = 32'h002081B3;
  localparam logic [31:0] W_LW   = 32'h0040A183;
  localparam logic [31:0] W_BEQ  = 32'h00208463;
  localparam logic [31:0] W_SW   = 32'h0020A223;
  localparam logic [31:0] W_SUB  = 32'h40208133;
  localparam logic [31:0] W_SRAI = 32'h40335293;
  localparam logic [31:0] W_NOP  = 32'h00000013;
  localparam logic [31:0] W_ILL  = 32'h0000007F;
  localparam logic [31:0] W_ADDI = 32'h00A00513;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic [31:0] instr, input logic zero, input logic [7:0] ctrl,
                   input logic [7:0] mask, input logic alu_chk, input logic [3:0] alu,
                   input logic ir_chk, input logic [31:0] ret);
    vec_t r;
    r.instr = instr; r.zero = zero; r.ctrl = ctrl; r.mask = mask;
    r.alu_chk = alu_chk; r.alu = alu; r.ir_chk = ir_chk; r.ret = ret;
    vq.push_back(r);
  endtask

  // Hold reset for two cycles, check the reset state, release on a falling edge
  task automatic do_reset(input logic [31:0] first_word);
    rst = 1'b0;
    ifc.iMemReadData = first_word;
    ifc.Zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ir", ifc.instruction, 32'h0000_0013);
    check("rst_retired", ifc.retired, 32'd0);
    check("rst_ctrl", 32'(ctrl_act & 8'hAE), 32'h80);
    check("rst_illegal", 32'(ifc.illegal), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    ifs.iMemReadData = W_ILL;
    ifs.Zero = 1'b0;
    ifc.iMemReadData = W_NOP;
    ifc.Zero = 1'b0;

    // Per-cycle table; masks drop fields that carry no meaning in that cycle
    v(W_ADD, 0, 8'h80, 8'hAE, 0, 4'h0, 0, 0);
    v(W_ADD, 0, 8'h00, 8'hAE, 0, 4'h0, 1, 0);
    v(W_ADD, 0, 8'h00, 8'hEE, 1, 4'h2, 1, 0);
    v(W_ADD, 0, 8'h28, 8'hFF, 1, 4'h2, 1, 0);
    v(W_LW, 0, 8'h80, 8'hAE, 0, 4'h0, 0, 1);
    v(W_LW, 0, 8'h00, 8'hAE, 0, 4'h0, 1, 1);
    v(W_LW, 0, 8'h40, 8'hEE, 1, 4'h2, 1, 1);
    v(W_LW, 0, 8'h44, 8'hEE, 1, 4'h2, 1, 1);
    v(W_LW, 0, 8'h78, 8'hFF, 1, 4'h2, 1, 1);
    v(W_BEQ, 1, 8'h80, 8'hAE, 0, 4'h0, 0, 2);
    v(W_BEQ, 1, 8'h00, 8'hAE, 0, 4'h0, 1, 2);
    v(W_BEQ, 1, 8'h09, 8'hFF, 1, 4'h6, 1, 2);
    v(W_BEQ, 0, 8'h80, 8'hAE, 0, 4'h0, 0, 3);
    v(W_BEQ, 0, 8'h00, 8'hAE, 0, 4'h0, 1, 3);
    v(W_BEQ, 0, 8'h08, 8'hFF, 1, 4'h6, 1, 3);
    v(W_SW, 0, 8'h80, 8'hAE, 0, 4'h0, 0, 4);
    v(W_SW, 0, 8'h00, 8'hAE, 0, 4'h0, 1, 4);
    v(W_SW, 0, 8'h40, 8'hEE, 1, 4'h2, 1, 4);
    v(W_SW, 0, 8'h4A, 8'hEF, 1, 4'h2, 1, 4);
    v(W_SUB, 0, 8'h80, 8'hAE, 0, 4'h0, 0, 5);
    v(W_SUB, 0, 8'h00, 8'hAE, 0, 4'h0, 1, 5);
    v(W_SUB, 0, 8'h00, 8'hEE, 1, 4'h6, 1, 5);
    v(W_SUB, 0, 8'h28, 8'hFF, 1, 4'h6, 1, 5);
    v(W_SRAI, 0, 8'h80, 8'hAE, 0, 4'h0, 0, 6);
    v(W_SRAI, 0, 8'h00, 8'hAE, 0, 4'h0, 1, 6);
    v(W_SRAI, 0, 8'h40, 8'hEE, 1, 4'hA, 1, 6);
    v(W_SRAI, 0, 8'h68, 8'hFF, 1, 4'hA, 1, 6);
    v(W_NOP, 0, 8'h80, 8'hAE, 0, 4'h0, 0, 7);

    @(negedge clk);
    do_reset(W_ADD);

    // Table run: cycle 1 of the first instruction starts at the release edge
    for (int i = 0; i < vq.size(); i++) begin
      ifc.iMemReadData = vq[i].instr;
      ifc.Zero = vq[i].zero;
      #1;
      $display("vec %0d: instr=%h zero=%0d ctrl=%b alu=%b retired=%0d",
               i, vq[i].instr, vq[i].zero, ctrl_act, ifc.ALUCtrl, ifc.retired);
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl_act & vq[i].mask), 32'(vq[i].ctrl & vq[i].mask));
      check($sformatf("vec%0d_retired", i), ifc.retired, vq[i].ret);
      if (vq[i].alu_chk) check($sformatf("vec%0d_aluctrl", i), 32'(ifc.ALUCtrl), 32'(vq[i].alu));
      if (vq[i].ir_chk) check($sformatf("vec%0d_ir", i), ifc.instruction, vq[i].instr);
      @(negedge clk);
    end

    // Illegal opcode: halting instance goes to ERR, skipping instance retires it in ID
    do_reset(W_ILL);
    #1;
    $display("seq illegal: released, both in IF");
    @(negedge clk); #1;
    check("halt_id_illegal", 32'(ifc.illegal), 32'd0);
    check("skip_id_loadpc", 32'(ifs.loadPC), 32'd1);
    check("skip_id_pcsrc", 32'(ifs.PCSrc), 32'd0);
    @(negedge clk); #1;
    check("skip_if_retired", ifs.retired, 32'd1);
    check("skip_if_imemread", 32'(ifs.iMemRead), 32'd1);
    check("skip_if_loadpc", 32'(ifs.loadPC), 32'd0);
    for (int c = 0; c < 20; c++) begin
      check($sformatf("err_cyc%0d", c),
            32'({ifc.illegal, ifc.iMemRead, ifc.RegWrite, ifc.MemWrite,
                 ifc.MemRead, ifc.loadPC, ifc.PCSrc}), 32'b1000000);
      check($sformatf("err_retired%0d", c), ifc.retired, 32'd0);
      @(negedge clk); #1;
    end
    $display("seq illegal: skip retired=%0d halt illegal=%0d", ifs.retired, ifc.illegal);
    #1 rst = 1'b0;
    #1;
    check("err_rst_illegal", 32'(ifc.illegal), 32'd0);
    check("err_rst_imemread", 32'(ifc.iMemRead), 32'd1);

    // Reset asserted in the MEM cycle of SW, after one ADD has retired
    do_reset(W_ADD);
    repeat (4) @(negedge clk);
    ifc.iMemReadData = W_SW;
    repeat (3) @(negedge clk);
    #1;
    check("sw_mem_memwrite", 32'(ifc.MemWrite), 32'd1);
    check("sw_mem_retired", ifc.retired, 32'd1);
    #1 rst = 1'b0;
    #1;
    $display("seq midreset: memwrite=%0d ir=%h retired=%0d", ifc.MemWrite, ifc.instruction, ifc.retired);
    check("midrst_memwrite", 32'(ifc.MemWrite), 32'd0);
    check("midrst_ir", ifc.instruction, 32'h0000_0013);
    check("midrst_retired", ifc.retired, 32'd0);
    check("midrst_strobes", 32'({ifc.RegWrite, ifc.loadPC, ifc.MemRead}), 32'd0);
    @(negedge clk);
    check("midrst_hold_memwrite", 32'(ifc.MemWrite), 32'd0);
    rst = 1'b1;
    ifc.iMemReadData = W_ADDI;
    #1;
    check("restart_if_imemread", 32'(ifc.iMemRead), 32'd1);
    @(negedge clk); #1;
    check("restart_id_imemread", 32'(ifc.iMemRead), 32'd0);
    check("restart_id_ir", ifc.instruction, W_ADDI);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
